// File: rtl/conv_pkg.sv
// Shared constants and types for the 5x5 convolution window generator.
package conv_pkg;

    localparam int PIXEL_W = 9;
    localparam int KSIZE   = 5;
    localparam int NTAPS   = KSIZE * KSIZE;

    typedef logic signed [PIXEL_W-1:0] pixel_t;
    typedef pixel_t window_t [NTAPS];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: combinational read of the old word at addr,
// write of the new word at the same addr on the clock edge.
module conv_line_buffer #(
    parameter int DEPTH = 516,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    assign dout = mem_r[addr];

    // Row storage write port; contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding 5x5 window generator over a raster pixel stream (valid/ready in and out).
// Optional statistics (win_count, stall counter) enabled by defining CONV_WIN_STATS_EN.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = 516,
    parameter int IMG_HEIGHT  = 516,
    parameter int PIXEL_WIDTH = PIXEL_W,
    parameter int KERNEL_SIZE = KSIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [PIXEL_WIDTH-1:0]   s_pixel,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [NTAPS*PIXEL_WIDTH-1:0]    win_pixels,
    output logic [$clog2(IMG_WIDTH)-1:0]    win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]   win_y,
    output logic                            frame_done,
    output logic [19:0]                     win_count
);

    localparam int XW  = $clog2(IMG_WIDTH);
    localparam int YW  = $clog2(IMG_HEIGHT);
    localparam int NLB = KSIZE - 1;

    localparam logic [XW-1:0] COL_LAST      = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST      = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] COL_FIRST_WIN = XW'(KSIZE - 1);
    localparam logic [YW-1:0] ROW_FIRST_WIN = YW'(KSIZE - 1);

    if (KERNEL_SIZE != KSIZE) begin : g_ksize_check
        $error("conv_window_gen: only KERNEL_SIZE=5 is supported");
    end

    state_t                 state_r;
    state_t                 state_s;
    logic [XW-1:0]          col_r;
    logic [YW-1:0]          row_r;
    logic                   win_valid_r;
    logic                   frame_done_r;
    logic [XW-1:0]          win_x_r;
    logic [YW-1:0]          win_y_r;
    logic [PIXEL_WIDTH-1:0] win_r     [NTAPS];
    logic [PIXEL_WIDTH-1:0] lb_in_s   [NLB];
    logic [PIXEL_WIDTH-1:0] lb_out_s  [NLB];
    logic [PIXEL_WIDTH-1:0] new_col_s [KSIZE];

    logic s_ready_s;
    logic accept_s;
    logic emit_s;
    logic col_wrap_s;
    logic last_pix_s;
    logic start_frame_s;
    logic done_pulse_s;

    assign col_wrap_s = (col_r == COL_LAST);
    assign last_pix_s = col_wrap_s && (row_r == ROW_LAST);
    // Windows only form once 5 rows and 5 columns are in hand, so none straddle a row edge.
    assign emit_s     = (row_r >= ROW_FIRST_WIN) && (col_r >= COL_FIRST_WIN);
    assign accept_s   = s_valid && s_ready_s;

    // Next-state and handshake decode.
    always_comb begin
        state_s       = state_r;
        s_ready_s     = 1'b0;
        start_frame_s = 1'b0;
        done_pulse_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s       = RUN;
                    start_frame_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                s_ready_s = !win_valid_r || win_ready;
                if (s_valid && s_ready_s && last_pix_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (!win_valid_r) begin
                    state_s      = IDLE;
                    done_pulse_s = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line buffer chain: LB0 takes the incoming pixel, each later buffer takes its predecessor's old word.
    assign lb_in_s[0] = s_pixel;
    for (genvar i = 1; i < NLB; i++) begin : g_lb_chain
        assign lb_in_s[i] = lb_out_s[i-1];
    end

    for (genvar i = 0; i < NLB; i++) begin : g_lb
        conv_line_buffer #(
            .DEPTH (IMG_WIDTH),
            .WIDTH (PIXEL_WIDTH),
            .AW    (XW)
        ) u_lb (
            .clk   (clk),
            .wr_en (accept_s),
            .addr  (col_r),
            .din   (lb_in_s[i]),
            .dout  (lb_out_s[i])
        );
    end

    // Column entering the window, oldest row (LB3) on top, live pixel at the bottom.
    for (genvar j = 0; j < NLB; j++) begin : g_new_col
        assign new_col_s[j] = lb_out_s[NLB-1-j];
    end
    assign new_col_s[KSIZE-1] = s_pixel;

    // 5x5 window shift register: every accept moves the window one column to the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                win_r[k] <= {PIXEL_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_r[r*KSIZE + c] <= win_r[r*KSIZE + c + 1];
                end
                win_r[r*KSIZE + KSIZE - 1] <= new_col_s[r];
            end
        end
    end

    // State, raster position and output window control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            col_r        <= {XW{1'b0}};
            row_r        <= {YW{1'b0}};
            win_valid_r  <= 1'b0;
            win_x_r      <= {XW{1'b0}};
            win_y_r      <= {YW{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            frame_done_r <= done_pulse_s;
            if (start_frame_s) begin
                col_r <= {XW{1'b0}};
                row_r <= {YW{1'b0}};
            end else if (accept_s) begin
                if (col_wrap_s) begin
                    col_r <= {XW{1'b0}};
                    row_r <= last_pix_s ? {YW{1'b0}} : row_r + YW'(1'b1);
                end else begin
                    col_r <= col_r + XW'(1'b1);
                end
            end
            // A freshly loaded window wins over the consume of the previous one.
            if (accept_s && emit_s) begin
                win_valid_r <= 1'b1;
                win_x_r     <= col_r - COL_FIRST_WIN;
                win_y_r     <= row_r - ROW_FIRST_WIN;
            end else if (win_ready) begin
                win_valid_r <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_pack
        assign win_pixels[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win_r[k];
    end

    assign s_ready    = s_ready_s;
    assign win_valid  = win_valid_r;
    assign win_x      = win_x_r;
    assign win_y      = win_y_r;
    assign frame_done = frame_done_r;

`ifdef CONV_WIN_STATS_EN
    localparam logic [19:0] WIN_COUNT_MAX = 20'hF_FFFF;

    logic [19:0] win_count_r;
    logic [31:0] stall_count_r;

    // Window handshake count (saturating) and output stall cycle count, both restarted per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_count_r   <= 20'd0;
            stall_count_r <= 32'd0;
        end else if (start_frame_s) begin
            win_count_r   <= 20'd0;
            stall_count_r <= 32'd0;
        end else begin
            if (win_valid_r && win_ready && (win_count_r != WIN_COUNT_MAX)) begin
                win_count_r <= win_count_r + 20'd1;
            end
            if (win_valid_r && !win_ready) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign win_count = win_count_r;
`else
    assign win_count = 20'd0;
`endif

endmodule
